// File: rtl/ntsc_fb_arbiter.sv
// rtl/ntsc_fb_arbiter.sv - framebuffer SRAM arbiter: line prefetch into ping-pong buffer plus host writes
module ntsc_fb_arbiter #(
  parameter int DATA_W     = 8,
  parameter int ROW_W      = 8,
  parameter int IDX_W      = 7,
  parameter int LINE_WORDS = 94,
  parameter int BURST      = 8
) (
  input  logic                   clk_i,
  input  logic                   reset,
  input  logic                   line_start,
  input  logic [ROW_W-1:0]       fetch_line,
  output logic [ROW_W+IDX_W-1:0] sram_addr,
  output logic                   sram_we,
  output logic [DATA_W-1:0]      sram_wdata,
  input  logic [DATA_W-1:0]      sram_rdata,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ROW_W+IDX_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [IDX_W-1:0]       pix_rd_idx,
  output logic [DATA_W-1:0]      pix_rd_data,
  output logic                   busy,
  output logic                   underrun,
  input  logic                   underrun_clr
);

  localparam int AW    = ROW_W + IDX_W;
  localparam int DEPTH = 1 << IDX_W;
  localparam int BW    = $clog2(BURST + 1);
  localparam logic [BW-1:0]    BURST_C = BW'(BURST);
  localparam logic [IDX_W-1:0] LAST_C  = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              front_q, front_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [IDX_W-1:0]  word_q, word_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic              tag_v_q, tag_v_d;
  logic              tag_bank_q, tag_bank_d;
  logic [IDX_W-1:0]  tag_idx_q, tag_idx_d;
  logic              underrun_q, underrun_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] pix_q;
  logic              rd_issue, ready, buf_we, host_we;

  logic [DATA_W-1:0] lbuf [0:2*DEPTH-1];

  always_comb begin
    state_d    = state_q;
    front_d    = front_q;
    row_d      = row_q;
    word_d     = word_q;
    burst_d    = burst_q;
    tag_v_d    = 1'b0;
    tag_bank_d = tag_bank_q;
    tag_idx_d  = tag_idx_q;
    underrun_d = underrun_q;
    rd_issue   = 1'b0;
    ready      = 1'b0;
    buf_we     = tag_v_q;
    if (underrun_clr) underrun_d = 1'b0;
    case (state_q)
      IDLE:  ready = 1'b1;
      FETCH: begin
        if (wr_valid && burst_q == BURST_C) begin
          ready   = 1'b1;
          burst_d = '0;
        end else begin
          rd_issue   = 1'b1;
          tag_v_d    = 1'b1;
          tag_bank_d = ~front_q;
          tag_idx_d  = word_q;
          word_d     = word_q + 1'b1;
          burst_d    = wr_valid ? burst_q + 1'b1 : '0;
          if (word_q == LAST_C) state_d = DRAIN;
        end
      end
      DRAIN: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new line pre-empts everything; a late fetch loses both its landing and in-flight words.
    if (line_start) begin
      front_d  = ~front_q;
      row_d    = fetch_line;
      word_d   = '0;
      burst_d  = '0;
      state_d  = FETCH;
      rd_issue = 1'b0;
      tag_v_d  = 1'b0;
      if (state_q != IDLE) begin
        underrun_d = 1'b1;
        buf_we     = 1'b0;
      end
    end
  end

  assign host_we = wr_valid && ready && !reset;

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (host_we) begin
      addr_d  = wr_addr;
      wdata_d = wr_data;
    end else if (rd_issue) begin
      addr_d = {row_q, word_q};
    end
  end

  assign sram_addr   = reset ? '0 : addr_d;
  assign sram_wdata  = reset ? '0 : wdata_d;
  assign sram_we     = host_we;
  assign wr_ready    = ready;
  assign busy        = (state_q != IDLE);
  assign underrun    = underrun_q;
  assign pix_rd_data = pix_q;

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q    <= IDLE;
      front_q    <= 1'b0;
      row_q      <= '0;
      word_q     <= '0;
      burst_q    <= '0;
      tag_v_q    <= 1'b0;
      tag_bank_q <= 1'b0;
      tag_idx_q  <= '0;
      underrun_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      pix_q      <= '0;
    end else begin
      state_q    <= state_d;
      front_q    <= front_d;
      row_q      <= row_d;
      word_q     <= word_d;
      burst_q    <= burst_d;
      tag_v_q    <= tag_v_d;
      tag_bank_q <= tag_bank_d;
      tag_idx_q  <= tag_idx_d;
      underrun_q <= underrun_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      pix_q      <= lbuf[{front_q, pix_rd_idx}];
    end
  end

  always_ff @(posedge clk_i) begin
    if (buf_we && !reset) lbuf[{tag_bank_q, tag_idx_q}] <= sram_rdata;
  end

endmodule

// File: tb/tb_ntsc_fb_arbiter.sv
// tb/tb_ntsc_fb_arbiter.sv - randomized scoreboard bench for ntsc_fb_arbiter
module tb_ntsc_fb_arbiter;
  localparam int LW = 94;
  localparam int BST = 8;

  logic        clk_i = 1'b0;
  logic        reset, line_start, sram_we, wr_valid, wr_ready, busy, underrun, underrun_clr;
  logic [7:0]  fetch_line, sram_wdata, sram_rdata, wr_data, pix_rd_data;
  logic [14:0] sram_addr, wr_addr;
  logic [6:0]  pix_rd_idx;

  always #5 clk_i = ~clk_i;

  ntsc_fb_arbiter dut (
    .clk_i(clk_i), .reset(reset), .line_start(line_start), .fetch_line(fetch_line),
    .sram_addr(sram_addr), .sram_we(sram_we), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .pix_rd_idx(pix_rd_idx), .pix_rd_data(pix_rd_data), .busy(busy), .underrun(underrun),
    .underrun_clr(underrun_clr)
  );

  int n_cmp = 0, n_fail = 0;
  logic [7:0] seed;

  function automatic logic [7:0] init_val(input logic [14:0] a);
    if (a[14:7] == 8'd5) return 8'({1'b0, a[6:0]} + 8'd1);
    return 8'(a * 15'd37) ^ seed ^ a[12:5];
  endfunction

  // SRAM model: unwritten words come from init_val
  logic [7:0] mem [0:32767];
  bit         written [0:32767];
  always @(posedge clk_i) begin
    if (sram_we) begin
      mem[sram_addr]     <= sram_wdata;
      written[sram_addr] <= 1'b1;
    end
    sram_rdata <= written[sram_addr] ? mem[sram_addr] : init_val(sram_addr);
  end

  // reference model
  int sram_ref [0:32767];
  int bank_m [0:1][0:127];
  int old_bank [0:127];
  int front_m;
  int exp_rd[$];
  int exp_pix[$];
  logic pix_req = 1'b0, pix_req_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  always @(posedge clk_i) pix_req_q <= pix_req;

  always @(negedge clk_i) begin
    if (!reset) begin
      if (busy && !wr_ready && !line_start) begin
        if (exp_rd.size() == 0) chk("unexpected_read", {17'd0, sram_addr}, 32'hFFFF_FFFF);
        else chk("read_addr", {17'd0, sram_addr}, exp_rd.pop_front());
        chk("read_we", {31'd0, sram_we}, 32'd0);
      end
      if (wr_valid || sram_we) begin
        chk("host_we", {31'd0, sram_we}, {31'd0, wr_valid && wr_ready});
        if (sram_we) begin
          chk("host_addr", {17'd0, sram_addr}, {17'd0, wr_addr});
          chk("host_data", {24'd0, sram_wdata}, {24'd0, wr_data});
        end
      end
      if (pix_req_q) begin
        int e;
        e = (exp_pix.size() != 0) ? exp_pix.pop_front() : -2;
        if (e == -2) chk("pix_queue", 32'd0, 32'd1);
        else if (e >= 0) chk("pix_data", {24'd0, pix_rd_data}, e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic line_go(input int row);
    exp_rd.delete();
    for (int i = 0; i < LW; i++) exp_rd.push_back(row * 128 + i);
    front_m ^= 1;
    for (int i = 0; i < LW; i++) bank_m[front_m ^ 1][i] = sram_ref[row * 128 + i];
    line_start = 1'b1;
    fetch_line = 8'(row);
    cyc();
    line_start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    forever begin
      @(negedge clk_i);
      if (!busy) break;
      n++;
      if (n > 500) begin
        chk("fetch_timeout", 32'd1, 32'd0);
        break;
      end
    end
    cyc();
  endtask

  task automatic pix_check(input int idx);
    pix_rd_idx = 7'(idx);
    pix_req = 1'b1;
    exp_pix.push_back(bank_m[front_m][idx]);
    cyc();
    pix_req = 1'b0;
  endtask

  task automatic pix_sweep();
    pix_check(0);
    pix_check(LW - 1);
    for (int k = 0; k < 6; k++) pix_check($urandom_range(0, LW - 1));
    cyc();
    cyc();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, run, rem;
    int runs[$];
    logic [14:0] a;
    logic [7:0]  d;
    seed = 8'($urandom);
    for (int i = 0; i < 32768; i++) sram_ref[i] = int'(init_val(15'(i)));
    for (int b = 0; b < 2; b++) for (int i = 0; i < 128; i++) bank_m[b][i] = -1;
    front_m = 0;
    reset = 1'b1; line_start = 1'b0; fetch_line = '0; wr_valid = 1'b0; wr_addr = '0;
    wr_data = '0; pix_rd_idx = '0; underrun_clr = 1'b0;
    cyc(); cyc();
    cyc();
    reset = 1'b0;
    @(negedge clk_i);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    chk("rst_we", {31'd0, sram_we}, 32'd0);
    chk("rst_addr", {17'd0, sram_addr}, 32'd0);
    chk("rst_wdata", {24'd0, sram_wdata}, 32'd0);
    chk("rst_pix", {24'd0, pix_rd_data}, 32'd0);
    chk("rst_ready", {31'd0, wr_ready}, 32'd1);
    cyc();

    // plain fetch of row 5, then swap and read it back
    line_go(5);
    wait_done(n);
    chk("busy_cycles_plain", n, 32'd95);
    line_go($urandom_range(8, 199));
    wait_done(n);
    pix_check(10);
    pix_sweep();

    // host holding wr_valid through a fetch gets one slot per BURST reads
    wr_valid = 1'b1; wr_addr = 15'h0123; wr_data = 8'hA5; sram_ref[15'h0123] = 8'hA5;
    line_go($urandom_range(8, 199));
    n = 0; run = 0; runs.delete();
    forever begin
      @(negedge clk_i);
      if (!busy) break;
      n++;
      if (!wr_ready) run++;
      else begin
        runs.push_back(run);
        run = 0;
      end
      if (n > 500) begin
        chk("fetch_timeout_host", 32'd1, 32'd0);
        break;
      end
    end
    cyc();
    wr_valid = 1'b0;
    chk("busy_cycles_host", n, 32'(LW + (LW - 1) / BST + 1));
    rem = LW;
    for (int k = 0; rem > 0; k++) begin
      int r;
      r = (rem > BST) ? BST : rem;
      if (k < runs.size()) chk("read_run", runs[k], r);
      else chk("read_run_missing", 32'd0, r);
      rem -= r;
    end
    chk("read_run_count", runs.size(), 32'(LW / BST + ((LW % BST) != 0 ? 1 : 0)));
    chk("sram_123", {24'd0, mem[15'h0123]}, 32'hA5);
    line_go($urandom_range(8, 199));
    wait_done(n);
    pix_sweep();

    // idle host writes
    for (int k = 0; k < 3; k++) begin
      a = {8'($urandom_range(200, 255)), 7'($urandom)};
      d = 8'($urandom);
      wr_valid = 1'b1; wr_addr = a; wr_data = d; sram_ref[a] = d;
      @(negedge clk_i);
      chk("idle_ready", {31'd0, wr_ready}, 32'd1);
      chk("idle_we", {31'd0, sram_we}, 32'd1);
      cyc();
    end
    wr_valid = 1'b0;
    cyc();
    chk("idle_mem", {24'd0, mem[a]}, {24'd0, d});

    // late line_start after 50 cycles
    for (int i = 0; i < 128; i++) old_bank[i] = bank_m[front_m][i];
    line_go($urandom_range(8, 199));
    repeat (49) cyc();
    line_go($urandom_range(8, 199));
    for (int i = 48; i < LW; i++) bank_m[front_m][i] = (i == 48) ? -1 : old_bank[i];
    @(negedge clk_i);
    chk("underrun_set", {31'd0, underrun}, 32'd1);
    cyc();
    pix_check(49);
    pix_check(10);
    pix_sweep();
    underrun_clr = 1'b1;
    cyc();
    underrun_clr = 1'b0;
    @(negedge clk_i);
    chk("underrun_clr", {31'd0, underrun}, 32'd0);
    cyc();
    wait_done(n);

    // alternating banks
    for (int k = 0; k < 2; k++) begin
      line_go($urandom_range(8, 199));
      wait_done(n);
      pix_sweep();
    end

    // reset at word 20 of a fetch
    line_go($urandom_range(8, 199));
    repeat (20) cyc();
    reset = 1'b1;
    exp_rd.delete();
    for (int i = 0; i < 128; i++) bank_m[front_m ^ 1][i] = -1;
    front_m = 0;
    cyc();
    reset = 1'b0;
    @(negedge clk_i);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_we", {31'd0, sram_we}, 32'd0);
    chk("abort_underrun", {31'd0, underrun}, 32'd0);
    cyc();
    repeat (5) cyc();
    line_go($urandom_range(8, 199));
    wait_done(n);
    chk("busy_cycles_after_abort", n, 32'd95);
    line_go($urandom_range(8, 199));
    wait_done(n);
    pix_sweep();

    chk("read_queue_empty", exp_rd.size(), 32'd0);
    chk("pix_queue_empty", exp_pix.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ntsc_fb_arbiter.md
Name: ntsc_fb_arbiter

Overview:
- Shares one single-port framebuffer SRAM between two requesters: the NTSC/PAL scanout path and a host write port.
- Each line, prefetches one line of pixel words from SRAM into a ping-pong line buffer, one line ahead of display.
- The luma generator reads the front bank by pixel index.
- Host writes fill SRAM slots the fetch does not use; a starvation guard guarantees host progress during a fetch.

Parameters:
- DATA_W, 8, SRAM/pixel word width
- ROW_W, 8, width of fetch_line; SRAM address = {row, word index}
- IDX_W, 7, word index width (line buffer depth 2**IDX_W per bank)
- LINE_WORDS, 94, words fetched per line (1..2**IDX_W)
- BURST, 8, max consecutive fetch reads while a host write is pending

Ports:
- clk_i  in  1  system clock
- reset  in  1  synchronous, active-high reset
- line_start  in  1  one-cycle pulse at start of each active line
- fetch_line  in  ROW_W  row to prefetch; sampled when line_start=1
- sram_addr  out  ROW_W+IDX_W  SRAM address
- sram_we  out  1  SRAM write strobe
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid one cycle after read address
- wr_valid  in  1  host write request
- wr_ready  out  1  host owns the SRAM port this cycle
- wr_addr  in  ROW_W+IDX_W  host write address
- wr_data  in  DATA_W  host write data
- pix_rd_idx  in  IDX_W  front-bank word index from scanout
- pix_rd_data  out  DATA_W  front-bank word, registered
- busy  out  1  fetch in progress (FETCH or DRAIN)
- underrun  out  1  sticky: line_start arrived before fetch completed
- underrun_clr  in  1  clears underrun

Behaviour:
- Reset:
  - State IDLE; front bank 0 (back bank 1); word count, burst count and read-tag valid are 0.
  - sram_we, sram_addr, sram_wdata, pix_rd_data, busy, underrun are all 0.
  - Line buffer contents are not cleared.
- FSM states: IDLE, FETCH, DRAIN.
- line_start, in any state:
  - Swap banks; latch fetch_line; word count=0; burst count=0; next state FETCH.
  - If state != IDLE, set underrun and discard any in-flight read tag; data returning next cycle is not written.
- FETCH, per cycle, one of:
  - Host slot, when wr_valid=1 and burst count==BURST: wr_ready=1; burst count=0; no read issued.
  - Otherwise, fetch read:
    - sram_addr={row, word}, sram_we=0, wr_ready=0.
    - Tag (bank=back, idx=word) is registered.
    - Word count +1.
    - Burst count +1 if wr_valid, else burst count=0.
  - After the read with word==LINE_WORDS-1, go to DRAIN.
- DRAIN: one cycle. Last read data lands; wr_ready=1; then go to IDLE.
- IDLE: wr_ready=1.
- Host transfer:
  - Occurs when wr_valid && wr_ready.
  - Drive sram_we=1, sram_addr=wr_addr, sram_wdata=wr_data in the same cycle.
  - wr_ready does not depend on wr_valid, except via the FETCH slot rule.
  - When wr_ready=1 and wr_valid=0: sram_we=0, sram_addr holds its last value.
- Read data return: cycle after a read, if the tag is valid, write sram_rdata into line buffer [tag bank][tag idx].
- Scanout read:
  - pix_rd_data <= buffer[front][pix_rd_idx], one-cycle latency.
  - Bank swap takes effect for reads issued in the cycle after line_start.
- Simultaneous line_start and DRAIN: the in-flight last word is discarded; underrun set (state != IDLE).
- underrun_clr and a set event in the same cycle: set wins.
- Reset mid-fetch: abort immediately, no further SRAM reads, state as at reset.
- Fetch length: LINE_WORDS reads take LINE_WORDS + host-slot cycles + 1 DRAIN cycle.
  - With LINE_WORDS=94 and BURST=8 this is at most 94+11+1=106 cycles, far below the 910/1135-clock line.

Test Plan:
1. Reset, SRAM preloaded with row 5 word i = i+1. Pulse line_start with fetch_line=5, wr_valid=0.
   -> sram_addr sequence 0x280..0x2DD on consecutive cycles; busy high for 95 cycles.
   -> After a second line_start, pix_rd_idx=10 gives pix_rd_data=11 one cycle later.
2. Hold wr_valid=1 during a fetch (wr_addr=0x0123, wr_data=0xA5).
   -> Exactly one wr_ready cycle after every 8 fetch reads.
   -> SRAM[0x123]=0xA5.
   -> Fetch completes in 94+11+1 cycles and fetched data is correct.
3. Idle, wr_valid=1 for 3 cycles with different addresses.
   -> wr_ready=1 all 3 cycles; 3 SRAM writes with sram_we=1.
4. Second line_start 50 cycles after the first.
   -> underrun=1; fetch restarts at word 0 with the new row.
   -> Word 49 of the old fetch is not written into the now-front bank.
   -> underrun_clr pulse returns underrun to 0.
5. Fill bank with row A, swap, fill with row B, swap.
   -> pix_rd_data alternates A/B contents per line; index 0 and index 93 both correct.
6. Assert reset at word 20 of a fetch.
   -> Next cycle: busy=0, sram_we=0, underrun=0, no further reads.
   -> A subsequent line_start fetches normally.
